// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the button-driven ALU.
// Queues op/operand commands, pulses one ALU button per command, returns the captured result.
`timescale 1ns/1ps
module alu_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int N     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [3:0]             cmd_op,
   input  logic [N-1:0]           cmd_data,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [N-1:0]           rsp_result,
   output logic [2:0]             rsp_error,
   output logic [3:0]             rsp_flags,
   output logic                   rsp_illegal,
   output logic [13:0]            alu_buttons,
   output logic [N-1:0]           alu_busIn,
   input  logic [N-1:0]           alu_busOut,
   input  logic [2:0]             alu_error,
   input  logic [3:0]             alu_flags,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } state_e;

   logic [3:0]   op_mem_q   [DEPTH];
   logic [N-1:0] data_mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   state_e        state_q, state_d;
   logic [3:0]    op_q, op_d;
   logic [13:0]   buttons_q, buttons_d;
   logic [N-1:0]  busin_q, busin_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [N-1:0]  rsp_result_q, rsp_result_d;
   logic [2:0]    rsp_error_q, rsp_error_d;
   logic [3:0]    rsp_flags_q, rsp_flags_d;
   logic          rsp_illegal_q, rsp_illegal_d;

   logic          push;
   logic          pop;
   logic [3:0]    head_op;
   logic [N-1:0]  head_data;
   logic          op_active;

   assign cmd_ready = (count_q < CW'(DEPTH));
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state_q == IDLE) && (count_q != '0);
   assign head_op   = op_mem_q[rd_ptr_q];
   assign head_data = data_mem_q[rd_ptr_q];
   assign op_active = (op_q != 4'd0) && (op_q != 4'hF);

   always_ff @(posedge clk) begin
      if (push) begin
         op_mem_q[wr_ptr_q]   <= cmd_op;
         data_mem_q[wr_ptr_q] <= cmd_data;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      buttons_d     = buttons_q;
      busin_d       = busin_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_result_d  = rsp_result_q;
      rsp_error_d   = rsp_error_q;
      rsp_flags_d   = rsp_flags_q;
      rsp_illegal_d = rsp_illegal_q;
      unique case (state_q)
         IDLE: begin
            if (pop) begin
               op_d    = head_op;
               busin_d = head_data;
               // ops 1..14 map to buttons 0..13; 0 and 15 press nothing
               for (int i = 0; i < 14; i++) begin
                  buttons_d[i] = (head_op == 4'(i + 1));
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // error lines are only meaningful while the button is held
            rsp_error_d = op_active ? alu_error : 3'b000;
            buttons_d   = '0;
            state_d     = CAPTURE;
         end
         CAPTURE: begin
            rsp_result_d  = alu_busOut;
            rsp_flags_d   = alu_flags;
            rsp_illegal_d = (op_q == 4'hF);
            rsp_valid_d   = 1'b1;
            state_d       = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         state_q       <= IDLE;
         op_q          <= '0;
         buttons_q     <= '0;
         busin_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_result_q  <= '0;
         rsp_error_q   <= '0;
         rsp_flags_q   <= '0;
         rsp_illegal_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         state_q       <= state_d;
         op_q          <= op_d;
         buttons_q     <= buttons_d;
         busin_q       <= busin_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_result_q  <= rsp_result_d;
         rsp_error_q   <= rsp_error_d;
         rsp_flags_q   <= rsp_flags_d;
         rsp_illegal_q <= rsp_illegal_d;
      end
   end

   assign alu_buttons = buttons_q;
   assign alu_busIn   = busin_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_error   = rsp_error_q;
   assign rsp_flags   = rsp_flags_q;
   assign rsp_illegal = rsp_illegal_q;
   assign fifo_count  = count_q;
   assign busy        = (state_q != IDLE) || (count_q != '0);

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream command front-end for the 16-bit button-driven ALU.
- Accepts opcode/operand commands over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the ALU as a single-cycle one-hot button pulse with a stable bus input.
- Captures the ALU's result, error and flags, and returns them over a valid/ready response interface.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- N, 16, operand/result width; matches the ALU bus width.

Ports:
- clk  in  1  rising-edge clock, shared with the ALU.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  4  operation code: 0 NOP, 1..14 ALU ops, 15 illegal.
- cmd_data  in  N  operand presented on the ALU bus input.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumer ready.
- rsp_result  out  N  ALU Ans register captured.
- rsp_error  out  3  {+ovfl, -udfl, x trunc} captured.
- rsp_flags  out  4  {negative, A>B, A=B, A<B} captured.
- rsp_illegal  out  1  command had op 15; no ALU action taken.
- alu_buttons  out  14  one-hot button pulse to the ALU.
- alu_busIn  out  N  operand to the ALU.
- alu_busOut  in  N  ALU Ans register.
- alu_error  in  3  ALU error outputs (combinational, valid while a button is held).
- alu_flags  in  4  ALU flag outputs.
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- fifo_count  out  log2(DEPTH)+1  number of FIFO entries.

Behaviour:
- Reset (async, rst_n=0): the following take effect immediately:
  - FIFO empties; fifo_count=0.
  - FSM goes to IDLE.
  - alu_buttons=0, alu_busIn=0.
  - rsp_valid=0; rsp_result, rsp_error, rsp_flags and rsp_illegal all 0.
  - cmd_ready=1 after reset releases.
- Reset does not clear the ALU registers; clearing them is done with an op 12 (Clr) command.
- FIFO:
  - cmd_ready = (fifo_count < DEPTH), registered-state based, with no bypass.
  - A push occurs when cmd_valid & cmd_ready.
  - A pop occurs only on the IDLE→ISSUE transition.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
  - A push into a full FIFO cannot occur (cmd_ready=0).
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If fifo_count>0: pop the head into the issue register (op, data).
  - If op is in 1..14, alu_buttons ← 1<<(op-1); otherwise alu_buttons ← 0.
  - alu_busIn ← data. Next state ISSUE.
- ISSUE:
  - alu_buttons is high for exactly this one cycle; alu_busIn is stable.
  - At the end of the cycle, capture alu_error into rsp_error (the errors are combinational and valid only while the button is held).
  - For op 0 or 15, capture rsp_error=0.
  - Next state CAPTURE; alu_buttons ← 0.
- CAPTURE:
  - The ALU registers have updated at the previous edge.
  - rsp_result ← alu_busOut, rsp_flags ← alu_flags, rsp_illegal ← (op==15).
  - For op 15 the result and flags are still sampled (ALU unchanged).
  - rsp_valid ← 1. Next state RESP.
- RESP:
  - Hold all rsp_* outputs stable while rsp_valid=1.
  - On rsp_ready, rsp_valid ← 0 and next state is IDLE.
- alu_busIn keeps its value after ISSUE until the next pop.
- Latency:
  - A push into an empty FIFO while in IDLE appears in the FIFO next cycle; the pop happens that cycle.
  - Button pulse occurs 2 cycles after the push cycle.
  - rsp_valid rises 4 cycles after the push cycle.
  - Minimum 4 cycles per command with rsp_ready tied high.
- Ordering: responses are returned strictly in command order; exactly one response per accepted command.
- Backpressure: while in RESP, the FIFO keeps accepting commands until full.
- Reset mid-operation (any state): the in-flight command and buffered commands are discarded with no response. A button pulse truncates asynchronously to 0.

Test Plan:
- Reset then ldA/ldB/add:
  - Stimulus: push op8 data 5, op9 data 3, op1 data 0; stub ALU returns busOut=8, flags=4'b0100, error=0 on the + pulse.
  - Required: buttons pulses 0x0080, 0x0100, 0x0001 (one cycle each, busIn 5/3/0 during each); three responses in order, last rsp_result=8, rsp_flags=4'b0100.
- Error capture:
  - Stimulus: push op1; stub drives alu_error=3'b100 only during the button pulse.
  - Required: rsp_error=3'b100; the next command with stub error=0 gives rsp_error=0.
- Illegal and NOP:
  - Stimulus: push op15 data 0xFFFF, then op0.
  - Required: alu_buttons stays 0 throughout; responses carry rsp_illegal=1, then 0, both with rsp_result = current stub busOut.
- Full FIFO and backpressure:
  - Stimulus: rsp_ready=0, push 6 commands back-to-back.
  - Required: 5 accepted (1 in RESP + 4 buffered); cmd_ready=0 with fifo_count=4; after rsp_ready=1, 5 responses in order and fifo_count returns to 0.
- Reset mid-command:
  - Stimulus: assert rst_n=0 during ISSUE of op2.
  - Required: alu_buttons goes to 0 the same cycle; rsp_valid=0, fifo_count=0; no response after release.
- Throughput:
  - Stimulus: rsp_ready=1, 8 commands streamed.
  - Required: a button pulse every 4 cycles; total 32 cycles from first pop to last rsp handshake.
